// File: rtl/kernel_accum_if.sv
// kernel_accum_if: handshake and result bundle between the neighbour
// sequencer/accumulator and its user.
//   start     : request a new 8-neighbour pass (user -> block)
//   ready     : block is idle and will accept start (block -> user)
//   select    : demux select code, [0:3] with bit 0 as MSB (block -> demux)
//   k_d       : neighbour value for the current select (demux -> block)
//   out_valid : one-cycle pulse, results valid (block -> user)
//   sum       : neighbour sum of the last pass
//   max_val   : largest neighbour value of the last pass
//   max_sel   : select code where max_val first occurred
interface kernel_accum_if #(
  parameter int DW = 4,
  parameter int SW = 7
);
  logic          start;
  logic          ready;
  logic [0:3]    select;
  logic [DW-1:0] k_d;
  logic          out_valid;
  logic [SW-1:0] sum;
  logic [DW-1:0] max_val;
  logic [3:0]    max_sel;

  modport master (
    output start, k_d,
    input  ready, select, out_valid, sum, max_val, max_sel
  );

  modport slave (
    input  start, k_d,
    output ready, select, out_valid, sum, max_val, max_sel
  );
endinterface

// File: rtl/kernel_accum.sv
// kernel_accum: steps the kernel neighbour demux through select codes
// 1..NCODES, one per clock, accumulating the returned k_d values and
// tracking the largest value and its first select code.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : kernel_accum_if slave modport (start/ready handshake, demux
//         select and k_d return, out_valid pulse with sum/max results)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready=1, select=0, waiting for start
// RUN   | select=1..NCODES, one neighbour sampled and summed per edge
// DONE  | out_valid pulse for one cycle, then back to IDLE
module kernel_accum #(
  parameter int DW     = 4,
  parameter int SW     = 7,
  parameter int NCODES = 8
) (
  input  logic          clk,
  input  logic          rst,
  kernel_accum_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] LAST_SEL = 4'(NCODES);

  state_t        state_q, state_d;
  logic          ready_q, ready_d;
  logic [0:3]    select_q, select_d;
  logic          out_valid_q, out_valid_d;
  logic [SW-1:0] acc_q, acc_d;
  logic [DW-1:0] run_max_q, run_max_d;
  logic [3:0]    run_sel_q, run_sel_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [DW-1:0] max_val_q, max_val_d;
  logic [3:0]    max_sel_q, max_sel_d;

  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    select_d    = select_q;
    out_valid_d = out_valid_q;
    acc_d       = acc_q;
    run_max_d   = run_max_q;
    run_sel_d   = run_sel_q;
    sum_d       = sum_q;
    max_val_d   = max_val_q;
    max_sel_d   = max_sel_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = RUN;
          ready_d  = 1'b0;
          select_d = 4'd1;
          acc_d    = '0;
        end
      end

      RUN: begin
        acc_d = acc_q + SW'(bus.k_d);
        // First code seeds the max; later codes must be strictly larger,
        // so ties keep the lowest select code.
        if ((select_q == 4'd1) || (bus.k_d > run_max_q)) begin
          run_max_d = bus.k_d;
          run_sel_d = select_q;
        end
        if (select_q == LAST_SEL) begin
          sum_d       = acc_d;
          max_val_d   = run_max_d;
          max_sel_d   = run_sel_d;
          select_d    = 4'd0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          select_d = select_q + 4'd1;
        end
      end

      DONE: begin
        out_valid_d = 1'b0;
        ready_d     = 1'b1;
        state_d     = IDLE;
      end

      default: begin
        state_d     = IDLE;
        ready_d     = 1'b1;
        select_d    = 4'd0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      select_q    <= 4'd0;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      run_max_q   <= '0;
      run_sel_q   <= 4'd0;
      sum_q       <= '0;
      max_val_q   <= '0;
      max_sel_q   <= 4'd0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      select_q    <= select_d;
      out_valid_q <= out_valid_d;
      acc_q       <= acc_d;
      run_max_q   <= run_max_d;
      run_sel_q   <= run_sel_d;
      sum_q       <= sum_d;
      max_val_q   <= max_val_d;
      max_sel_q   <= max_sel_d;
    end
  end

  assign bus.ready     = ready_q;
  assign bus.select    = select_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.max_val   = max_val_q;
  assign bus.max_sel   = max_sel_q;

endmodule

// File: tb/tb_kernel_accum.sv
// tb_kernel_accum: directed bench for kernel_accum. A behavioural demux
// returns nbs[code] for the current select; a table of neighbour sets
// with hand-computed sum/max/max_sel is run pass by pass, followed by
// sequences for continuous start, mid-idle reset and mid-run reset.
module tb_kernel_accum;

  logic clk;
  logic rst;
  logic [31:0] nbs;  // nibble c-1 holds the neighbour value for code c

  int n_cmp;
  int n_err;
  int prev_sum, prev_max, prev_sel;

  kernel_accum_if #(.DW(4), .SW(7)) bus ();

  kernel_accum #(.DW(4), .SW(7), .NCODES(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    int s;
    s = int'(bus.select);
    bus.k_d = 4'h0;
    if (s >= 1 && s <= 8) bus.k_d = nbs[(s-1)*4 +: 4];
  end

  typedef struct {
    logic [31:0] v;
    int          e_sum;
    int          e_max;
    int          e_sel;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " ready"},     int'(bus.ready), 1);
    chk({tag, " select"},    int'(bus.select), 0);
    chk({tag, " out_valid"}, int'(bus.out_valid), 0);
    chk({tag, " sum"},       int'(bus.sum), 0);
    chk({tag, " max_val"},   int'(bus.max_val), 0);
    chk({tag, " max_sel"},   int'(bus.max_sel), 0);
  endtask

  // One full pass from IDLE, sampled on negedges.
  task automatic run_pass(input logic [31:0] v, input int es, input int em, input int ems);
    nbs = v;
    @(negedge clk);
    chk("idle ready", int'(bus.ready), 1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk("run select", int'(bus.select), c);
      chk("run ready", int'(bus.ready), 0);
      chk("run out_valid", int'(bus.out_valid), 0);
      if (c == 8) begin
        chk("held sum", int'(bus.sum), prev_sum);
        chk("held max_val", int'(bus.max_val), prev_max);
        chk("held max_sel", int'(bus.max_sel), prev_sel);
      end
      @(negedge clk);
    end
    chk("done out_valid", int'(bus.out_valid), 1);
    chk("done ready", int'(bus.ready), 0);
    chk("done select", int'(bus.select), 0);
    chk("sum", int'(bus.sum), es);
    chk("max_val", int'(bus.max_val), em);
    chk("max_sel", int'(bus.max_sel), ems);
    prev_sum = es;
    prev_max = em;
    prev_sel = ems;
    @(negedge clk);
    chk("post out_valid", int'(bus.out_valid), 0);
    chk("post ready", int'(bus.ready), 1);
    chk("post sum hold", int'(bus.sum), es);
  endtask

  initial begin
    int pulses;
    n_cmp = 0;
    n_err = 0;
    prev_sum = 0;
    prev_max = 0;
    prev_sel = 0;
    nbs = 32'h0;
    bus.start = 1'b0;

    vecs[0] = '{v: 32'h07654321, e_sum: 28,  e_max: 7,  e_sel: 7};
    vecs[1] = '{v: 32'h77777777, e_sum: 56,  e_max: 7,  e_sel: 1};
    vecs[2] = '{v: 32'h00000000, e_sum: 0,   e_max: 0,  e_sel: 1};
    vecs[3] = '{v: 32'hFFFFFFFF, e_sum: 120, e_max: 15, e_sel: 1};
    vecs[4] = '{v: 32'h00000000, e_sum: 0,   e_max: 0,  e_sel: 1};
    vecs[5] = '{v: 32'h40192993, e_sum: 37,  e_max: 9,  e_sel: 2};
    vecs[6] = '{v: 32'hF0000000, e_sum: 15,  e_max: 15, e_sel: 8};

    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_pass(vecs[i].v, vecs[i].e_sum, vecs[i].e_max, vecs[i].e_sel);
    end

    // Reset while idle with non-zero results held.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals("idle rst");
    rst = 1'b0;
    prev_sum = 0;
    prev_max = 0;
    prev_sel = 0;
    @(negedge clk);

    // start held high: a pass every 10 cycles, nothing accepted while busy.
    nbs = 32'h07654321;
    bus.start = 1'b1;
    for (int k = 0; k < 30; k++) begin
      int m;
      @(negedge clk);
      m = k % 10;
      chk("cont select", int'(bus.select), (m < 8) ? m + 1 : 0);
      chk("cont ready", int'(bus.ready), (m == 9) ? 1 : 0);
      chk("cont out_valid", int'(bus.out_valid), (m == 8) ? 1 : 0);
      if (m == 8) chk("cont sum", int'(bus.sum), 28);
    end
    bus.start = 1'b0;
    prev_sum = 28;
    prev_max = 7;
    prev_sel = 7;
    @(negedge clk);
    chk("cont stop select", int'(bus.select), 0);

    // Reset mid-RUN at select=4: abort, no pulse, then a clean pass.
    nbs = 32'hFFFFFFFF;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort select before rst", int'(bus.select), 4);
    rst = 1'b1;
    #1;
    chk_reset_vals("mid rst");
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.out_valid) pulses++;
    end
    chk("abort out_valid pulses", pulses, 0);
    prev_sum = 0;
    prev_max = 0;
    prev_sel = 0;
    run_pass(32'h40192993, 37, 9, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/kernel_accum.md
Name: kernel_accum

Overview:
- Sequencer/accumulator stage wrapped around the kernel neighbour demux.
- On each start request it steps the demux select through all eight neighbour codes, 1..8 (tl, tr, bl, br, r, l, t, b), one per clock.
- It consumes the returned k_d value each cycle.
- It produces the neighbour sum plus the value and select code of the largest neighbour, for the downstream kernel arithmetic.

Parameters:
- DW, 4, width of k_d from the demux (unsigned).
- SW, 7, width of the sum output; must hold 8*(2^DW-1) = 120.
- NCODES, 8, number of neighbour codes stepped (1..NCODES); fixed at 8 for this design.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new 8-neighbour pass; sampled only when ready=1.
- ready  output  1  high in IDLE; block accepts start.
- select  output  4  demux select. Declared [0:3], bit 0 is MSB. Value 0 in IDLE/DONE, 1..8 in RUN.
- k_d  input  DW  selected neighbour value returned combinationally by the demux for the current select.
- out_valid  output  1  one-cycle pulse; sum/max_val/max_sel valid this cycle.
- sum  output  SW  sum of the 8 neighbour values of the last pass.
- max_val  output  DW  largest neighbour value of the last pass.
- max_sel  output  4  select code (1..8) at which max_val first occurred.

Behaviour:
- Reset values (async, immediate):
  - state=IDLE, ready=1, select=0, out_valid=0.
  - sum=0, max_val=0, max_sel=0, internal accumulators cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - ready=1, select=0.
  - start=1 at an edge: clear the accumulator, load select=1, go to RUN.
  - ready drops in the same edge.
- RUN (exactly 8 cycles):
  - k_d is combinational from select and is sampled at the same edge that advances select.
  - Each edge: acc <= acc + k_d, zero-extended to SW bits; no overflow is possible.
  - Max tracking, select=1: max_val <= k_d, max_sel <= 1 unconditionally.
  - Max tracking, select>1: update only if k_d > current max (strict). Ties keep the lowest select code.
  - select=8: the edge latches the final sum/max into the output registers, sets select=0, goes to DONE.
  - Otherwise select <= select+1.
- DONE (1 cycle): out_valid=1, ready=0, then IDLE.
- Output hold: sum/max_val/max_sel hold until the next DONE; they are not cleared on start.
- Latency: start sampled at edge E, select=1..8 during cycles E+1..E+8, out_valid high during cycle E+9. Earliest next start is sampled at edge E+10.
- start while ready=0 is ignored, not queued.
- select never takes values 9..15; select=0 means demux idle (k_d=0).
- rst asserted mid-RUN: pass aborted, all outputs to reset values, no out_valid pulse.
- rst deasserted: IDLE on the next edge.

Test Plan:
- Reset: assert rst for 3 cycles mid-idle -> ready=1, select=0, out_valid=0, sum=0, max_val=0, max_sel=0.
- Basic pass: neighbours tl..b = 1,2,3,4,5,6,7,0; pulse start -> select steps 1..8 on consecutive cycles, out_valid 9 cycles after the start edge, sum=28, max_val=7, max_sel=7.
- Ties and all-max: all neighbours = 7 -> sum=56, max_val=7, max_sel=1. All neighbours = 0 -> sum=0, max_val=0, max_sel=1.
- Full-scale DW: k_d forced to 15 each RUN cycle -> sum=120, no wrap. Then a second pass with all 0 -> sum=0 and previous outputs held until that pass's out_valid.
- Start during busy: start held high continuously -> passes start every 10 cycles, no start accepted during RUN/DONE, ready low for exactly 9 cycles per pass.
- Reset mid-op: rst pulsed when select=4 -> select=0 immediately, no out_valid. New start after release -> a clean pass gives correct sum with no residue from the aborted pass.
